sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parametrised FIFO that succeeds the dual-clock FIFO for same-domain buffering. Adds programmable almost-full and almost-empty flags, a fill-level output, and a selectable first-word-fall-through (FWFT) read mode. Overflow and underflow are reported as pulses. Used between producer and consumer stages that share one clock.

## Interface
- `DATA_WIDTH`, 8: width of `wdata` and `rdata`.
- `FIFO_SIZE`, 16: depth in entries; power of two, ≥ 2.
- `PTR_WIDTH`, `$clog2(FIFO_SIZE)`: address width; derived, not overridden.
- `AF_LEVEL`, `FIFO_SIZE-2`: `almost_full` asserts when `count` ≥ `AF_LEVEL`. Range 1..`FIFO_SIZE`.
- `AE_LEVEL`, 2: `almost_empty` asserts when `count` ≤ `AE_LEVEL`. Range 0..`FIFO_SIZE-1`.
- `FWFT`, 0: 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write request.
- `wdata`  in  `DATA_WIDTH`  write data.
- `full`  out  1  FIFO holds `FIFO_SIZE` entries.
- `almost_full`  out  1  `count` ≥ `AF_LEVEL`.
- `overflow`  out  1  one-cycle pulse: the previous cycle's write was rejected.
- `rd_en`  in  1  read request (pop).
- `rdata`  out  `DATA_WIDTH`  read data.
- `empty`  out  1  FIFO holds 0 entries.
- `almost_empty`  out  1  `count` ≤ `AE_LEVEL`.
- `underflow`  out  1  one-cycle pulse: the previous cycle's read was rejected.
- `count`  out  `PTR_WIDTH+1`  current fill level, 0..`FIFO_SIZE`.

## Operation
- **Pointers.** `wr_ptr` and `rd_ptr` are `PTR_WIDTH+1` bits wide. The MSB is a wrap bit; the low `PTR_WIDTH` bits address memory.
  - `count = wr_ptr - rd_ptr`, modulo 2^(`PTR_WIDTH+1`).
  - `full` when the MSBs differ and the low bits are equal.
  - `empty` when the pointers are equal.
- **Write.** A write is accepted when `wr_en && !full`: `mem[wr_ptr]` ← `wdata`, `wr_ptr` increments.
  - `wr_en && full` is rejected: no state change, and `overflow` = 1 on the next cycle.
- **Read.** A read is accepted when `rd_en && !empty`: `rd_ptr` increments.
  - `rd_en && empty` is rejected: `underflow` = 1 on the next cycle.
- **Simultaneous requests.** The accept decision uses only the flags at the current edge.
  - At `full`, with `wr_en` and `rd_en` both high: the read is accepted and the write is rejected with `overflow`. `count` becomes `FIFO_SIZE-1`.
  - At `empty`, with both high: the write is accepted and the read is rejected with `underflow`. `count` becomes 1. There is no bypass path.
  - Otherwise, both accepted together leaves `count` unchanged.
- **Read data, FWFT=0.** On an accepted read, `rdata` ← `mem[rd_ptr]`, registered. At all other times `rdata` holds its last value.
- **Read data, FWFT=1.** `rdata` = `mem[rd_ptr[PTR_WIDTH-1:0]]` continuously. It is valid whenever `!empty`, and is undefined-but-stable when `empty`. `rd_en` pops the displayed word.
- **Wrap-around.** Pointers roll over naturally. Ordering and `count` stay correct across any number of wraps.
- **Reset** (`rst_n` = 0, at any time, including mid-transfer):
  - pointers = 0, so `count` = 0;
  - `empty` = 1, `almost_empty` = 1, `full` = 0, `almost_full` = 0;
  - `overflow` = 0, `underflow` = 0;
  - `rdata` = 0 when FWFT=0.
  - Memory contents are not cleared.

## Timing
- Flags and `count` are combinational decodes of the registered pointers only. There is no input-to-flag combinational path, and all flags update on the edge that commits the request.
- Write-to-read latency:
  - FWFT=0: a write at edge N sets `empty` = 0 after edge N. A read issued at edge N+1 presents `rdata` after edge N+1.
  - FWFT=1: the word appears on `rdata` after edge N, together with `empty` = 0.
- `overflow` and `underflow` are registered pulses, exactly one cycle per rejected request. Back-to-back rejected requests keep the pulse high continuously.
- Sustained throughput: one write and one read per cycle.

## Structure
- Shared package `fifo_pkg` holds:
  - the FWFT mode constants `FIFO_MODE_STD` = 0 and `FIFO_MODE_FWFT` = 1;
  - the pointer-width helper function;
  - the default `DATA_WIDTH` and `FIFO_SIZE`.
- One sub-module, `fifo_dp_mem`: a simple dual-port array with one synchronous write port and one asynchronous read port. It is parametrised by `DATA_WIDTH` and `FIFO_SIZE`, and is reusable by the dual-clock FIFO.
- Pointer logic, flag decode, and error pulses live in `sync_fifo`.

## Test plan
- **FULL.** Reset, then 16 writes of 0x01..0x10 → after the 16th edge `full` = 1, `count` = 16, `almost_full` set from the 14th write; `overflow` = 0.
- **EMPTY / order.** After FULL, 16 reads → `rdata` sequence 0x01..0x10 (FWFT=0: one cycle after each `rd_en`); then `empty` = 1, `count` = 0, `almost_empty` set once `count` ≤ 2.
- **OVERFLOW / UNDERFLOW.** 17 writes → a single `overflow` pulse after the 17th edge, and `count` stays 16. 17 reads → a single `underflow` pulse, and `count` stays 0.
- **Simultaneous.**
  - At `full`, one cycle of `wr_en` = `rd_en` = 1 → `count` = 15, `overflow` pulse, the oldest word is popped.
  - At `empty`, the same → `count` = 1, `underflow` pulse.
- **Wrap / concurrent.** 200 cycles of random `wr_en`/`rd_en` → the scoreboard matches every word, `count` always equals writes minus reads, no spurious error pulses. Run with both FWFT=0 and FWFT=1.
- **Reset mid-operation.** With `count` = 9, pulse `rst_n` low asynchronously (not clock-aligned) → `empty` = 1, `count` = 0, `rdata` = 0 immediately; the next write/read returns the new data only.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO family.
// Mode selectors, default sizes and the pointer-width helper.
package fifo_pkg;

   localparam int FIFO_MODE_STD  = 0;
   localparam int FIFO_MODE_FWFT = 1;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_FIFO_SIZE  = 16;

   function automatic int ptr_width(input int size);
      return (size < 2) ? 1 : $clog2(size);
   endfunction

endpackage

// File: rtl/fifo_dp_mem.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
// Contents are never cleared, so reset does not touch the array.
module fifo_dp_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FIFO_SIZE  = DEF_FIFO_SIZE,
   localparam int AW        = ptr_width(FIFO_SIZE)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [FIFO_SIZE];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with level flags, fill count and optional FWFT read.
// Flags decode the registered pointers only; error pulses are registered.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FIFO_SIZE  = DEF_FIFO_SIZE,
   localparam int PTR_WIDTH = ptr_width(FIFO_SIZE),
   parameter int AF_LEVEL   = FIFO_SIZE - 2,
   parameter int AE_LEVEL   = 2,
   parameter int FWFT       = FIFO_MODE_STD
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  full,
   output logic                  almost_full,
   output logic                  overflow,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  empty,
   output logic                  almost_empty,
   output logic                  underflow,
   output logic [PTR_WIDTH:0]    count
);

   localparam logic [PTR_WIDTH:0] PTR_ONE = (PTR_WIDTH+1)'(1);
   localparam logic [PTR_WIDTH:0] AF_CNT  = (PTR_WIDTH+1)'(AF_LEVEL);
   localparam logic [PTR_WIDTH:0] AE_CNT  = (PTR_WIDTH+1)'(AE_LEVEL);

   logic [PTR_WIDTH:0]    wr_ptr;
   logic [PTR_WIDTH:0]    rd_ptr;
   logic                  wr_acc;
   logic                  rd_acc;
   logic [DATA_WIDTH-1:0] mem_rdata;

   // Accept decisions look only at the flags of the current edge.
   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;

   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]) &&
                  (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]);

   assign almost_full  = (count >= AF_CNT);
   assign almost_empty = (count <= AE_CNT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
         overflow  <= wr_en && full;
         underflow <= rd_en && empty;
      end
   end

   fifo_dp_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_SIZE  (FIFO_SIZE)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr[PTR_WIDTH-1:0]),
      .wdata (wdata),
      .raddr (rd_ptr[PTR_WIDTH-1:0]),
      .rdata (mem_rdata)
   );

   generate
      if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
         assign rdata = mem_rdata;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] rdata_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rdata_q <= '0;
            end else if (rd_acc) begin
               rdata_q <= mem_rdata;
            end
         end

         assign rdata = rdata_q;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: standard and FWFT instances share stimulus.
// A queue model predicts each cycle; a monitor compares after every edge.
module tb_sync_fifo;

   localparam int DW = 8;
   localparam int SZ = 16;

   typedef struct {
      int         cnt;
      bit         full;
      bit         empty;
      bit         af;
      bit         ae;
      bit         ov;
      bit         un;
      logic [7:0] rstd;
      bit         fv;
      logic [7:0] fw;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          wr_en;
   logic          rd_en;
   logic [DW-1:0] wdata;

   logic          s_full, s_af, s_ov, s_empty, s_ae, s_un;
   logic [DW-1:0] s_rdata;
   logic [4:0]    s_count;
   logic          f_full, f_af, f_ov, f_empty, f_ae, f_un;
   logic [DW-1:0] f_rdata;
   logic [4:0]    f_count;

   int checks = 0;
   int errors = 0;

   logic [7:0] mq[$];
   logic [7:0] std_last;
   exp_t       expq[$];

   sync_fifo #(.DATA_WIDTH(DW), .FIFO_SIZE(SZ), .FWFT(0)) u_std (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (wr_en),
      .wdata        (wdata),
      .full         (s_full),
      .almost_full  (s_af),
      .overflow     (s_ov),
      .rd_en        (rd_en),
      .rdata        (s_rdata),
      .empty        (s_empty),
      .almost_empty (s_ae),
      .underflow    (s_un),
      .count        (s_count)
   );

   sync_fifo #(.DATA_WIDTH(DW), .FIFO_SIZE(SZ), .FWFT(1)) u_fw (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (wr_en),
      .wdata        (wdata),
      .full         (f_full),
      .almost_full  (f_af),
      .overflow     (f_ov),
      .rd_en        (rd_en),
      .rdata        (f_rdata),
      .empty        (f_empty),
      .almost_empty (f_ae),
      .underflow    (f_un),
      .count        (f_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp,
                  $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      std_last = '0;
   endtask

   // Drive one cycle of requests and predict the state after the edge.
   task automatic step(input bit w, input bit r, input logic [7:0] d);
      exp_t e;
      bit   aw;
      bit   ar;
      @(negedge clk);
      wr_en = w;
      rd_en = r;
      wdata = d;
      aw = w && (mq.size() < SZ);
      ar = r && (mq.size() > 0);
      e.ov = w && !aw;
      e.un = r && !ar;
      if (ar) std_last = mq.pop_front();
      if (aw) mq.push_back(d);
      e.cnt   = mq.size();
      e.full  = (e.cnt == SZ);
      e.empty = (e.cnt == 0);
      e.af    = (e.cnt >= SZ - 2);
      e.ae    = (e.cnt <= 2);
      e.rstd  = std_last;
      e.fv    = (e.cnt > 0);
      e.fw    = e.fv ? mq[0] : 8'h00;
      expq.push_back(e);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         chk("s_count", 32'(s_count), 32'(e.cnt));
         chk("f_count", 32'(f_count), 32'(e.cnt));
         chk("s_full", 32'(s_full), 32'(e.full));
         chk("f_full", 32'(f_full), 32'(e.full));
         chk("s_empty", 32'(s_empty), 32'(e.empty));
         chk("f_empty", 32'(f_empty), 32'(e.empty));
         chk("s_af", 32'(s_af), 32'(e.af));
         chk("f_af", 32'(f_af), 32'(e.af));
         chk("s_ae", 32'(s_ae), 32'(e.ae));
         chk("f_ae", 32'(f_ae), 32'(e.ae));
         chk("s_ovf", 32'(s_ov), 32'(e.ov));
         chk("f_ovf", 32'(f_ov), 32'(e.ov));
         chk("s_unf", 32'(s_un), 32'(e.un));
         chk("f_unf", 32'(f_un), 32'(e.un));
         chk("s_rdata", 32'(s_rdata), 32'(e.rstd));
         if (e.fv) chk("f_rdata", 32'(f_rdata), 32'(e.fw));
      end
   end

   task automatic chk_reset_state(input string tag);
      chk({tag, "_s_count"}, 32'(s_count), 0);
      chk({tag, "_f_count"}, 32'(f_count), 0);
      chk({tag, "_s_empty"}, 32'(s_empty), 1);
      chk({tag, "_f_empty"}, 32'(f_empty), 1);
      chk({tag, "_s_ae"}, 32'(s_ae), 1);
      chk({tag, "_f_ae"}, 32'(f_ae), 1);
      chk({tag, "_s_full"}, 32'(s_full), 0);
      chk({tag, "_f_af"}, 32'(f_af), 0);
      chk({tag, "_s_af"}, 32'(s_af), 0);
      chk({tag, "_s_ovf"}, 32'(s_ov), 0);
      chk({tag, "_f_unf"}, 32'(f_un), 0);
      chk({tag, "_s_rdata"}, 32'(s_rdata), 0);
   endtask

   initial begin
      wr_en = 1'b0;
      rd_en = 1'b0;
      wdata = '0;
      rst_n = 1'b1;
      model_reset();
      #1 rst_n = 1'b0;
      #2 chk_reset_state("por");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 8'(i));
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);

      for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 8'($urandom));
      step(1'b1, 1'b1, 8'($urandom));
      step(1'b1, 1'b0, 8'($urandom));
      for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 8'h00);
      step(1'b1, 1'b1, 8'($urandom));
      step(1'b0, 1'b1, 8'h00);

      for (int i = 0; i < 200; i++) begin
         step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
              8'($urandom));
      end

      for (int i = 0; i < 20 && mq.size() > 0; i++) step(1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'($urandom));
      step(1'b0, 1'b0, 8'h00);

      @(negedge clk);
      #2 rst_n = 1'b0;
      model_reset();
      #1 chk_reset_state("mid");
      @(negedge clk);
      rst_n = 1'b1;

      step(1'b1, 1'b0, 8'hA5);
      step(1'b1, 1'b0, 8'h5A);
      step(1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b0, 8'h00);

      repeat (3) @(posedge clk);
      #2 chk("drain", 32'(expq.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
